// File: rtl/screen_pkg.sv
// screen_pkg: screen geometry and command encodings for the screen write sequencer.
package screen_pkg;
   localparam int SCR_COLS = 80;
   localparam int SCR_ROWS = 24;
   localparam int ADDR_W   = 11;
   localparam int CHAR_W   = 7;
   typedef enum logic [1:0] {
      OP_PUTCHAR = 2'd0,
      OP_CLR_EOL = 2'd1,
      OP_CLR_EOS = 2'd2,
      OP_CLR_ALL = 2'd3
   } cmd_op_e;
endpackage

// File: rtl/screen_addr_calc.sv
// screen_addr_calc: row*80+col cell address built from shifts, no multiplier.
module screen_addr_calc
   import screen_pkg::*;
(
   input  logic [4:0]        row_i,
   input  logic [6:0]        col_i,
   output logic [ADDR_W-1:0] addr_o
);
   assign addr_o = {row_i, 6'b0} + {2'b0, row_i, 4'b0} + {4'b0, col_i};
endmodule

// File: rtl/screen_write_seq.sv
// screen_write_seq: turns terminal commands into one-cell-per-cycle screen RAM writes.
module screen_write_seq
   import screen_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [6:0]        cmd_x,
   input  logic [4:0]        cmd_y,
   input  logic [CHAR_W-1:0] cmd_char,
   input  logic [4:0]        topline,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [CHAR_W-1:0] mem_wdata,
   output logic              mem_wren,
   output logic              busy,
   output logic              done
);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;
   localparam logic [6:0] COL_MAX  = 7'(SCR_COLS - 1);
   localparam logic [4:0] ROW_MAX  = 5'(SCR_ROWS - 1);
   logic [0:0]        state_q, state_d;
   logic [6:0]        col_q, col_d;
   logic [4:0]        row_q, row_d, stop_q, stop_d, row_nx;
   logic [CHAR_W-1:0] wdata_q, wdata_d;
   logic              put_q, put_d, bad_q, bad_d, eol_q, eol_d;
   logic              accept, in_range, last;
   screen_addr_calc u_addr (.row_i(row_q), .col_i(col_q), .addr_o(mem_addr));
   assign cmd_ready = state_q == ST_IDLE;
   assign busy      = state_q == ST_CLEAR;
   assign accept    = cmd_valid & cmd_ready;
   assign in_range  = (cmd_x <= COL_MAX) & (cmd_y <= ROW_MAX);
   assign row_nx    = row_q == ROW_MAX ? 5'd0 : row_q + 5'd1;
   // CLR_ALL reuses the end-of-screen stop rule with stop row = start row
   assign last      = busy & (col_q == COL_MAX) & (eol_q | (row_nx == stop_q));
   assign mem_wren  = put_q | busy;
   assign mem_wdata = wdata_q;
   assign done      = put_q | bad_q | last;
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      stop_d  = stop_q;
      eol_d   = eol_q;
      wdata_d = wdata_q;
      put_d   = accept & (cmd_op == OP_PUTCHAR) & in_range;
      bad_d   = accept & (cmd_op != OP_CLR_ALL) & ~in_range;
      if (busy) begin
         state_d = last ? ST_IDLE : ST_CLEAR;
         col_d   = col_q == COL_MAX ? 7'd0 : col_q + 7'd1;
         row_d   = col_q == COL_MAX ? row_nx : row_q;
      end else if (accept & ((cmd_op == OP_CLR_ALL) | in_range)) begin
         state_d = cmd_op == OP_PUTCHAR ? ST_IDLE : ST_CLEAR;
         col_d   = cmd_op == OP_CLR_ALL ? 7'd0 : cmd_x;
         row_d   = cmd_op == OP_CLR_ALL ? topline : cmd_y;
         stop_d  = topline;
         eol_d   = cmd_op == OP_CLR_EOL;
         wdata_d = cmd_op == OP_PUTCHAR ? cmd_char : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         stop_q  <= '0;
         eol_q   <= 1'b0;
         wdata_q <= '0;
         put_q   <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         stop_q  <= stop_d;
         eol_q   <= eol_d;
         wdata_q <= wdata_d;
         put_q   <= put_d;
         bad_q   <= bad_d;
      end
   end
endmodule

// File: tb/tb_screen_write_seq.sv
// tb_screen_write_seq: directed and random commands checked cycle by cycle against a cell-list model.
module tb_screen_write_seq;
   logic        clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [6:0]  cmd_x = '0, cmd_char = '0, mem_wdata;
   logic [4:0]  cmd_y = '0, topline = '0;
   logic [10:0] mem_addr;
   logic        mem_wren, busy, done;
   int tests = 0, fails = 0;
   bit rst_prev = 1'b1;
   typedef struct packed {
      logic        wren;
      logic [10:0] addr;
      logic [6:0]  data;
      logic        done;
      logic        busy;
   } ent_t;
   ent_t q[$];
   screen_write_seq dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_char(cmd_char),
      .topline(topline), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wren(mem_wren), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // Expected per-cycle outputs for an accepted command, one entry per cycle after acceptance.
   task automatic model(input int op, input int x, input int y, input int ch, input int top);
      int cells[$];
      if (op != 3 && (x > 79 || y > 23)) begin
         q.push_back('{1'b0, 11'd0, 7'd0, 1'b1, 1'b0});
         return;
      end
      if (op == 0) begin
         q.push_back('{1'b1, 11'(y * 80 + x), 7'(ch), 1'b1, 1'b0});
         return;
      end
      if (op == 3) begin
         for (int i = 0; i < 1920; i++) cells.push_back((top * 80 + i) % 1920);
      end else begin
         for (int c = x; c < 80; c++) cells.push_back(y * 80 + c);
         if (op == 2)
            for (int r = (y + 1) % 24; r != top; r = (r + 1) % 24)
               for (int c = 0; c < 80; c++) cells.push_back(r * 80 + c);
      end
      foreach (cells[i])
         q.push_back('{1'b1, 11'(cells[i]), 7'd0, 1'(i == cells.size() - 1), 1'b1});
   endtask
   task automatic tick(input logic v, input int op, input int x, input int y, input int ch,
                       input int top, input logic r, output bit acc);
      ent_t e;
      @(negedge clk);
      e = q.size() != 0 ? q.pop_front() : '0;
      chk("mem_wren", 32'(mem_wren), 32'(e.wren));
      chk("done", 32'(done), 32'(e.done));
      chk("busy", 32'(busy), 32'(e.busy));
      if (rst_prev) begin
         chk("rst_addr", 32'(mem_addr), 32'd0);
         chk("rst_wdata", 32'(mem_wdata), 32'd0);
      end else
         chk("cmd_ready", 32'(cmd_ready), 32'(!e.busy));
      if (e.wren) begin
         chk("mem_addr", 32'(mem_addr), 32'(e.addr));
         chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
      end
      reset     = r;
      cmd_valid = v;
      cmd_op    = 2'(op);
      cmd_x     = 7'(x);
      cmd_y     = 5'(y);
      cmd_char  = 7'(ch);
      topline   = 5'(top);
      acc = v && !r && !rst_prev && !e.busy;
      if (r) q.delete();
      if (acc) model(op, x, y, ch, top);
      rst_prev = r;
   endtask
   task automatic send(input int op, input int x, input int y, input int ch, input int top);
      bit acc;
      int n = 0;
      do begin
         tick(1'b1, op, x, y, ch, top, 1'b0, acc);
         n++;
      end while (!acc && n < 4000);
      chk("accept_timeout", 32'(acc), 32'd1);
   endtask
   task automatic idle(input int n, input int top);
      bit acc;
      repeat (n) tick(1'b0, 0, 0, 0, 0, top, 1'b0, acc);
   endtask
   initial begin
      bit acc;
      int n;
      repeat (3) tick(1'b0, 0, 0, 0, 0, 0, 1'b1, acc);
      idle(2, 0);
      send(0, 5, 2, 'o101, 0);
      send(0, 6, 2, 'o102, 0);
      idle(2, 0);
      send(0, 80, 0, 'o55, 0);
      idle(2, 0);
      send(1, 75, 3, 0, 0);
      idle(7, 0);
      send(2, 78, 22, 0, 0);
      idle(85, 0);
      send(2, 10, 4, 0, 5);
      idle(75, 5);
      send(3, 0, 0, 0, 5);
      idle(900, 5);
      idle(1025, 9);
      send(3, 7, 7, 0, 5);
      idle(99, 5);
      tick(1'b0, 0, 0, 0, 0, 5, 1'b1, acc);
      tick(1'b0, 0, 0, 0, 0, 5, 1'b1, acc);
      idle(1, 5);
      send(0, 79, 23, 'o177, 5);
      idle(2, 5);
      for (int i = 0; i < 120; i++) begin
         int p, op;
         p  = $urandom_range(99);
         op = p < 60 ? 0 : p < 80 ? 1 : p < 95 ? 2 : 3;
         send(op, $urandom_range(85), $urandom_range(25), $urandom_range(127), $urandom_range(23));
         repeat ($urandom_range(2)) tick(1'b0, 0, 0, 0, 0, $urandom_range(23), 1'b0, acc);
      end
      n = 0;
      while (q.size() != 0 && n < 4000) begin
         tick(1'b0, 0, 0, 0, 0, $urandom_range(23), 1'b0, acc);
         n++;
      end
      idle(2, 0);
      chk("drain_timeout", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
